// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator: state encoding,
// product width and signed range limits for an arbitrary accumulator width.
package product_acc_pkg;

   localparam int PROD_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_e;

   // Largest positive value of a w-bit two's complement number, right-aligned.
   function automatic logic [31:0] signed_max(input int unsigned w);
      return 32'((64'd1 << (w - 1)) - 64'd1);
   endfunction

   // Most negative value of a w-bit two's complement number, right-aligned.
   function automatic logic [31:0] signed_min(input int unsigned w);
      return 32'(64'd1 << (w - 1));
   endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating add of a signed product onto a signed accumulator;
// the sum is formed one bit wider so overflow shows up as a sign disagreement.
module sat_adder
   import product_acc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]      acc,
   input  logic [PROD_W-1:0] prod,
   output logic [W-1:0]      sum,
   output logic              ovf
);

   logic [W:0] acc_ext;
   logic [W:0] prod_ext;
   logic [W:0] raw;

   assign acc_ext  = {acc[W-1], acc};
   assign prod_ext = {{(W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
   assign raw      = acc_ext + prod_ext;

   always_comb begin
      ovf = raw[W] ^ raw[W-1];
      if (!ovf) begin
         sum = raw[W-1:0];
      end else if (raw[W]) begin
         sum = W'(signed_min(W));
      end else begin
         sum = W'(signed_max(W));
      end
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive signed products into a saturating accumulator and
// presents each frame total with a sticky saturation flag over valid/ready.
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int COUNT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_sat
);

   localparam int CNT_W = $clog2(COUNT + 1);

   acc_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             out_sat_q, out_sat_d;

   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;
   logic [CNT_W-1:0] count_inc;
   logic             accept;
   logic             deliver;

   sat_adder #(.W(ACC_W)) u_sat_adder (
      .acc  (acc_q),
      .prod (in_prod),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   assign accept    = in_valid & in_ready_q;
   assign deliver   = out_valid_q & out_ready;
   assign count_inc = count_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      sat_d       = sat_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      out_sat_d   = out_sat_q;

      if (clear) begin
         state_d     = IDLE;
         count_d     = '0;
         acc_d       = '0;
         sat_d       = 1'b0;
         in_ready_d  = 1'b1;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  if (count_inc == CNT_W'(COUNT)) begin
                     // Frame complete: latch the result and rearm the accumulator.
                     state_d     = HOLD;
                     count_d     = '0;
                     acc_d       = '0;
                     sat_d       = 1'b0;
                     sum_d       = add_sum;
                     out_sat_d   = sat_q | add_ovf;
                     in_ready_d  = 1'b0;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d = ACCUM;
                     count_d = count_inc;
                     acc_d   = add_sum;
                     sat_d   = sat_q | add_ovf;
                  end
               end
            end
            HOLD: begin
               if (deliver) begin
                  state_d     = IDLE;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d     = IDLE;
               count_d     = '0;
               acc_d       = '0;
               sat_d       = 1'b0;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, narrow-accumulator and
// single-product-frame instances driven from one clock and a shared reset.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // Instance a: defaults (ACC_W=16, COUNT=4)
   logic               a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
   logic signed [9:0]  a_in_prod;
   logic signed [15:0] a_out_sum;
   // Instance b: ACC_W=11, COUNT=4
   logic               b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
   logic signed [9:0]  b_in_prod;
   logic signed [10:0] b_out_sum;
   // Instance c: ACC_W=16, COUNT=1
   logic               c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sat;
   logic signed [9:0]  c_in_prod;
   logic signed [15:0] c_out_sum;

   product_accumulator #(.ACC_W(16), .COUNT(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum), .out_sat(a_out_sat)
   );

   product_accumulator #(.ACC_W(11), .COUNT(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_out_sum), .out_sat(b_out_sat)
   );

   product_accumulator #(.ACC_W(16), .COUNT(1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .clear(c_clear),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_prod(c_in_prod),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_sum(c_out_sum), .out_sat(c_out_sat)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic feed_a(input logic signed [9:0] p);
      a_in_valid = 1'b1;
      a_in_prod  = p;
      step();
   endtask

   task automatic feed_b(input logic signed [9:0] p);
      b_in_valid = 1'b1;
      b_in_prod  = p;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({a_in_ready, a_out_valid, a_out_sat, a_out_sum} !== {1'b1, 1'b0, 1'b0, 16'sd0}) begin
         n_bad++;
         $display("FAIL reset_a: got rdy=%b v=%b sat=%b sum=%0d, want rdy=1 v=0 sat=0 sum=0",
                  a_in_ready, a_out_valid, a_out_sat, a_out_sum);
      end
      n_vec++;
      if ({b_in_ready, b_out_valid, c_in_ready, c_out_valid} !== 4'b1010) begin
         n_bad++;
         $display("FAIL reset_bc: got b_rdy=%b b_v=%b c_rdy=%b c_v=%b, want 1 0 1 0",
                  b_in_ready, b_out_valid, c_in_ready, c_out_valid);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      a_out_ready = 1'b1;
      feed_a(10'sd5);
      feed_a(-10'sd3);
      feed_a(10'sd12);
      feed_a(10'sd100);
      a_in_valid = 1'b0;
      n_vec++;
      if ({a_out_valid, a_in_ready, a_out_sat, a_out_sum} !== {1'b1, 1'b0, 1'b0, 16'sd114}) begin
         n_bad++;
         $display("FAIL basic_result: got v=%b rdy=%b sat=%b sum=%0d, want v=1 rdy=0 sat=0 sum=114",
                  a_out_valid, a_in_ready, a_out_sat, a_out_sum);
      end
      $display("basic frame: sum=%0d sat=%b", a_out_sum, a_out_sat);
      step();
      n_vec++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL basic_after_deliver: got v=%b rdy=%b, want v=0 rdy=1", a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_saturate();
      b_out_ready = 1'b0;
      repeat (4) feed_b(10'sd256);
      b_in_valid = 1'b0;
      n_vec++;
      if ({b_out_valid, b_out_sat, b_out_sum} !== {1'b1, 1'b1, 11'sd1023}) begin
         n_bad++;
         $display("FAIL sat_pos: got v=%b sat=%b sum=%0d, want v=1 sat=1 sum=1023",
                  b_out_valid, b_out_sat, b_out_sum);
      end
      $display("sat frame: sum=%0d sat=%b", b_out_sum, b_out_sat);
      b_out_ready = 1'b1;
      step();
      b_out_ready = 1'b0;
      repeat (4) feed_b(-10'sd240);
      b_in_valid = 1'b0;
      n_vec++;
      if ({b_out_valid, b_out_sat, b_out_sum} !== {1'b1, 1'b0, -11'sd960}) begin
         n_bad++;
         $display("FAIL sat_neg_fresh: got v=%b sat=%b sum=%0d, want v=1 sat=0 sum=-960",
                  b_out_valid, b_out_sat, b_out_sum);
      end
      $display("neg frame: sum=%0d sat=%b", b_out_sum, b_out_sat);
      b_out_ready = 1'b1;
      step();
      n_vec++;
      if ({b_out_valid, b_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL sat_deliver: got v=%b rdy=%b, want v=0 rdy=1", b_out_valid, b_in_ready);
      end
   endtask

   task automatic test_backpressure();
      a_out_ready = 1'b0;
      repeat (4) feed_a(10'sd1);
      a_in_prod = 10'sd7;
      for (int i = 0; i < 6; i++) begin
         step();
         n_vec++;
         if ({a_out_valid, a_in_ready, a_out_sum} !== {1'b1, 1'b0, 16'sd4}) begin
            n_bad++;
            $display("FAIL bp_hold_%0d: got v=%b rdy=%b sum=%0d, want v=1 rdy=0 sum=4",
                     i, a_out_valid, a_in_ready, a_out_sum);
         end
      end
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      n_vec++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL bp_release: got v=%b rdy=%b, want v=0 rdy=1", a_out_valid, a_in_ready);
      end
      feed_a(10'sd7);
      repeat (3) feed_a(10'sd0);
      a_in_valid = 1'b0;
      n_vec++;
      if ({a_out_valid, a_out_sum} !== {1'b1, 16'sd7}) begin
         n_bad++;
         $display("FAIL bp_next_frame: got v=%b sum=%0d, want v=1 sum=7", a_out_valid, a_out_sum);
      end
      $display("backpressure frame: sum=%0d", a_out_sum);
      a_out_ready = 1'b1;
      step();
   endtask

   task automatic test_clear();
      feed_a(10'sd50);
      feed_a(10'sd60);
      a_clear    = 1'b1;
      a_in_prod  = 10'sd70;
      step();
      a_clear    = 1'b0;
      n_vec++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL clear_state: got v=%b rdy=%b, want v=0 rdy=1", a_out_valid, a_in_ready);
      end
      a_out_ready = 1'b0;
      feed_a(10'sd1);
      feed_a(10'sd2);
      feed_a(10'sd3);
      feed_a(10'sd4);
      a_in_valid = 1'b0;
      n_vec++;
      if ({a_out_valid, a_out_sat, a_out_sum} !== {1'b1, 1'b0, 16'sd10}) begin
         n_bad++;
         $display("FAIL clear_next_frame: got v=%b sat=%b sum=%0d, want v=1 sat=0 sum=10",
                  a_out_valid, a_out_sat, a_out_sum);
      end
      $display("post-clear frame: sum=%0d", a_out_sum);
      a_out_ready = 1'b1;
      step();
   endtask

   task automatic test_count1();
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      c_in_prod   = -10'sd16;
      step();
      n_vec++;
      if ({c_out_valid, c_in_ready, c_out_sum} !== {1'b1, 1'b0, -16'sd16}) begin
         n_bad++;
         $display("FAIL c1_first: got v=%b rdy=%b sum=%0d, want v=1 rdy=0 sum=-16",
                  c_out_valid, c_in_ready, c_out_sum);
      end
      c_in_prod = 10'sd256;
      step();
      n_vec++;
      if ({c_out_valid, c_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL c1_gap1: got v=%b rdy=%b, want v=0 rdy=1", c_out_valid, c_in_ready);
      end
      step();
      n_vec++;
      if ({c_out_valid, c_out_sum} !== {1'b1, 16'sd256}) begin
         n_bad++;
         $display("FAIL c1_second: got v=%b sum=%0d, want v=1 sum=256", c_out_valid, c_out_sum);
      end
      c_in_prod = 10'sd0;
      step();
      step();
      n_vec++;
      if ({c_out_valid, c_out_sat, c_out_sum} !== {1'b1, 1'b0, 16'sd0}) begin
         n_bad++;
         $display("FAIL c1_third: got v=%b sat=%b sum=%0d, want v=1 sat=0 sum=0",
                  c_out_valid, c_out_sat, c_out_sum);
      end
      $display("count1 stream done: last sum=%0d", c_out_sum);
      c_in_valid = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      a_out_ready = 1'b0;
      repeat (4) feed_a(10'sd9);
      a_in_valid = 1'b0;
      n_vec++;
      if ({a_out_valid, a_out_sum} !== {1'b1, 16'sd36}) begin
         n_bad++;
         $display("FAIL arst_hold: got v=%b sum=%0d, want v=1 sum=36", a_out_valid, a_out_sum);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({a_out_valid, a_in_ready, a_out_sum} !== {1'b0, 1'b1, 16'sd0}) begin
         n_bad++;
         $display("FAIL arst_immediate: got v=%b rdy=%b sum=%0d, want v=0 rdy=1 sum=0",
                  a_out_valid, a_in_ready, a_out_sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      feed_a(10'sd2);
      feed_a(10'sd4);
      feed_a(10'sd6);
      feed_a(10'sd8);
      a_in_valid = 1'b0;
      n_vec++;
      if ({a_out_valid, a_out_sat, a_out_sum} !== {1'b1, 1'b0, 16'sd20}) begin
         n_bad++;
         $display("FAIL arst_fresh_frame: got v=%b sat=%b sum=%0d, want v=1 sat=0 sum=20",
                  a_out_valid, a_out_sat, a_out_sum);
      end
      $display("post-reset frame: sum=%0d", a_out_sum);
      a_out_ready = 1'b1;
      step();
   endtask

   initial begin
      rst_n       = 1'b0;
      a_clear     = 1'b0; a_in_valid = 1'b0; a_in_prod = '0; a_out_ready = 1'b0;
      b_clear     = 1'b0; b_in_valid = 1'b0; b_in_prod = '0; b_out_ready = 1'b0;
      c_clear     = 1'b0; c_in_valid = 1'b0; c_in_prod = '0; c_out_ready = 1'b0;
      test_reset();
      test_basic();
      test_saturate();
      test_backpressure();
      test_clear();
      test_count1();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
